instr_fetch_unit: RTL and testbench

- Fetch stage that sits directly upstream of the stall control block.
- Owns the program counter and drives the instruction-memory address.
- Holds the IF/ID instruction register, whose opcode field feeds the stall control block's op input.
- Consumes that block's stall (hold PC) and stall_pm (replay previous instruction) outputs, plus a jump redirect from decode. Also keeps a saturating stall-cycle counter for debug.

---
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_fetch_unit.sv | 57 +++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the instruction memory (slave).
// The memory read is combinational: imem_rdata reflects imem_addr in the same cycle.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 32
);
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, and holds the IF/ID register whose
// opcode feeds the stall control block. Also counts stall cycles (saturating) for debug.
module instr_fetch_unit #(
   parameter int unsigned            ADDR_W    = 16,
   parameter int unsigned            INSTR_W   = 32,
   parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]     NOP_INSTR = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                stall_pm,
   input  logic                jump_en,
   input  logic [ADDR_W-1:0]   jump_addr,
   instr_fetch_unit_if.master  imem,
   output logic [INSTR_W-1:0]  instr_out,
   output logic [5:0]          op_out,
   output logic [ADDR_W-1:0]   pc_out,
   output logic                instr_valid,
   output logic [15:0]         stall_cnt
);

   logic [ADDR_W-1:0] pc;

   assign imem.imem_addr = pc;
   // Opcode comes from the registered instruction so the stall-block loop stays registered.
   assign op_out = instr_out[INSTR_W-1 -: 6];

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr_out   <= NOP_INSTR;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         if (jump_en)
            pc <= jump_addr;
         else if (!stall)
            pc <= pc + 1'b1;

         // A jump squashes the wrong-path fetch into a single bubble; pc_out keeps its value.
         if (jump_en) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
         end else if (!stall_pm) begin
            instr_out   <= imem.imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
         end

         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns {16'hA5A5, addr} for every address.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, stall_pm, jump_en;
   logic [15:0] jump_addr;
   logic [31:0] instr_out;
   logic [5:0]  op_out;
   logic [15:0] pc_out;
   logic        instr_valid;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) bus ();
   assign bus.imem_rdata = {16'hA5A5, bus.imem_addr};

   instr_fetch_unit #(
      .ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .NOP_INSTR(32'h0000_0000)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
      .jump_en(jump_en), .jump_addr(jump_addr), .imem(bus),
      .instr_out(instr_out), .op_out(op_out), .pc_out(pc_out),
      .instr_valid(instr_valid), .stall_cnt(stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b1; stall_pm = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234;
      step(); step();
      n_checks++;
      if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, 16'h0000); end
      n_checks++;
      if (instr_out !== 32'h0 || pc_out !== 16'h0 || instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ifid: got instr=%h pc_out=%h valid=%b expected 0/0/0", instr_out, pc_out, instr_valid);
      end
      n_checks++;
      if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", stall_cnt); end
   endtask

   task automatic test_free_run();
      reset = 1'b0; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_addr = 16'h0;
      for (int i = 1; i <= 5; i++) begin
         step();
         n_checks++;
         if (bus.imem_addr !== 16'(i) || instr_out !== {16'hA5A5, 16'(i - 1)} || pc_out !== 16'(i - 1) ||
             instr_valid !== 1'b1 || op_out !== 6'h29) begin
            n_fail++;
            $display("FAIL free_run[%0d]: got addr=%h instr=%h pc_out=%h valid=%b op=%h expected %h/%h/%h/1/29",
                     i, bus.imem_addr, instr_out, pc_out, instr_valid, op_out, 16'(i), {16'hA5A5, 16'(i - 1)}, 16'(i - 1));
         end
      end
      n_checks++;
      if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL free_run_cnt: got %h expected 0", stall_cnt); end
   endtask

   task automatic test_stall();
      // pc is 5 here
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (bus.imem_addr !== 16'h0005 || instr_out !== 32'hA5A5_0005 || pc_out !== 16'h0005) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pc_out=%h expected 0005/a5a50005/0005",
                     i, bus.imem_addr, instr_out, pc_out);
         end
      end
      stall = 1'b0; stall_pm = 1'b1;
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0006 || instr_out !== 32'hA5A5_0005 || pc_out !== 16'h0005 || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_pm: got addr=%h instr=%h pc_out=%h valid=%b expected 0006/a5a50005/0005/1",
                  bus.imem_addr, instr_out, pc_out, instr_valid);
      end
      n_checks++;
      if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt3: got %h expected 0003", stall_cnt); end
      stall_pm = 1'b0;
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0007 || instr_out !== 32'hA5A5_0006 || pc_out !== 16'h0006) begin
         n_fail++;
         $display("FAIL stall_resume: got addr=%h instr=%h pc_out=%h expected 0007/a5a50006/0006",
                  bus.imem_addr, instr_out, pc_out);
      end
   endtask

   task automatic test_jump();
      step(); step(); // pc 7 -> 9
      jump_en = 1'b1; jump_addr = 16'h0040; stall = 1'b1;
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0040 || instr_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 16'h0008) begin
         n_fail++;
         $display("FAIL jump_bubble: got addr=%h valid=%b instr=%h pc_out=%h expected 0040/0/00000000/0008",
                  bus.imem_addr, instr_valid, instr_out, pc_out);
      end
      n_checks++;
      if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL jump_cnt: got %h expected 0004", stall_cnt); end
      jump_en = 1'b0; stall = 1'b0;
      step();
      n_checks++;
      if (instr_out !== 32'hA5A5_0040 || pc_out !== 16'h0040 || instr_valid !== 1'b1 || bus.imem_addr !== 16'h0041) begin
         n_fail++;
         $display("FAIL jump_target: got instr=%h pc_out=%h valid=%b addr=%h expected a5a50040/0040/1/0041",
                  instr_out, pc_out, instr_valid, bus.imem_addr);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_addr [4];
      exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
      jump_en = 1'b1; jump_addr = 16'hFFFE;
      step();
      jump_en = 1'b0;
      n_checks++;
      if (bus.imem_addr !== exp_addr[0]) begin n_fail++; $display("FAIL wrap_load: got %h expected fffe", bus.imem_addr); end
      for (int i = 1; i < 4; i++) begin
         step();
         n_checks++;
         if (bus.imem_addr !== exp_addr[i] || pc_out !== exp_addr[i-1] || instr_out !== {16'hA5A5, exp_addr[i-1]}) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got addr=%h pc_out=%h instr=%h expected %h/%h/%h",
                     i, bus.imem_addr, pc_out, instr_out, exp_addr[i], exp_addr[i-1], {16'hA5A5, exp_addr[i-1]});
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      stall = 1'b1;
      step(); step(); step();
      n_checks++;
      if (stall_cnt !== 16'd7 || instr_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: got cnt=%h valid=%b expected 0007/1", stall_cnt, instr_valid);
      end
      reset = 1'b1; jump_en = 1'b1; jump_addr = 16'h0200;
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0000 || instr_out !== 32'h0 || instr_valid !== 1'b0 || stall_cnt !== 16'h0 || pc_out !== 16'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got addr=%h instr=%h valid=%b cnt=%h pc_out=%h expected 0000/00000000/0/0000/0000",
                  bus.imem_addr, instr_out, instr_valid, stall_cnt, pc_out);
      end
      reset = 1'b0; jump_en = 1'b0; stall = 1'b0;
      step();
      n_checks++;
      if (bus.imem_addr !== 16'h0001 || instr_out !== 32'hA5A5_0000 || pc_out !== 16'h0 || stall_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL post_reset: got addr=%h instr=%h pc_out=%h cnt=%h expected 0001/a5a50000/0000/0000",
                  bus.imem_addr, instr_out, pc_out, stall_cnt);
      end
   endtask

   task automatic test_saturation();
      int bad_pc = 0;
      stall = 1'b1;
      for (int i = 1; i <= 65540; i++) begin
         step();
         if (bus.imem_addr !== 16'h0001) bad_pc++;
         if (i == 65534) begin
            n_checks++;
            if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_minus1: got %h expected fffe", stall_cnt); end
         end
         if (i == 65535) begin
            n_checks++;
            if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", stall_cnt); end
         end
      end
      n_checks++;
      if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt); end
      n_checks++;
      if (bad_pc !== 0) begin n_fail++; $display("FAIL sat_pc: got %0d moved cycles expected 0", bad_pc); end
      stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_jump();
      test_wrap();
      test_reset_mid_stall();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
